// File: rtl/mem_align_stage_if.sv
// rtl/mem_align_stage_if.sv - data-memory request/response bus for mem_align_stage
//
// Purpose: groups the data-memory handshake between the memory stage and the
// data memory into one bundle.
// Ports (signals):
//   DMemReq    request valid (stage -> memory)
//   DMemAddr   word-aligned byte address (stage -> memory)
//   DMemWE     byte-lane write enables, bit 3 = bits 31:24 (stage -> memory)
//   DMemWData  lane-replicated store data (stage -> memory)
//   DMemReady  memory accepts write / returns read data this cycle (memory -> stage)
//   DMemRData  read data, valid with DMemReady on a read (memory -> stage)
// Modports: master = memory stage, slave = data memory.

interface mem_align_stage_if;
  logic        DMemReq;
  logic [31:0] DMemAddr;
  logic [3:0]  DMemWE;
  logic [31:0] DMemWData;
  logic        DMemReady;
  logic [31:0] DMemRData;

  modport master (
    output DMemReq, DMemAddr, DMemWE, DMemWData,
    input  DMemReady, DMemRData
  );

  modport slave (
    input  DMemReq, DMemAddr, DMemWE, DMemWData,
    output DMemReady, DMemRData
  );
endinterface

// File: rtl/mem_align_stage.sv
// rtl/mem_align_stage.sv - MIPS memory stage: load/store alignment and data-memory handshake
//
// Purpose: registers the execute-stage memory op (E->M), drives big-endian
// byte-lane enables and replicated store data, stalls while memory is not
// ready, and registers sign/zero-extended load data into writeback.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ValidE, MemReadE, MemWriteE execute-stage op qualifiers
//   MaskControlE[1:0]          store size (00 none, 01 SB, 10 SH, 11 SW)
//   LoadTypeE[2:0]             load type (1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU)
//   ALUOutE, WriteDataE        effective byte address, right-justified store data
//   dmem                       data-memory bus (master side)
//   StallM                     freeze earlier stages while memory is busy
//   MisalignM                  one-cycle misaligned-access exception pulse
//   ValidW, ReadDataW          writeback-stage result

module mem_align_stage (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ValidE,
  input  logic               MemReadE,
  input  logic               MemWriteE,
  input  logic [1:0]         MaskControlE,
  input  logic [2:0]         LoadTypeE,
  input  logic [31:0]        ALUOutE,
  input  logic [31:0]        WriteDataE,
  mem_align_stage_if.master  dmem,
  output logic               StallM,
  output logic               MisalignM,
  output logic               ValidW,
  output logic [31:0]        ReadDataW
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] MK_SB = 2'b01;
  localparam logic [1:0] MK_SH = 2'b10;
  localparam logic [1:0] MK_SW = 2'b11;

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LW  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  // E->M pipeline register
  logic        valid_m;
  logic        rd_m;
  logic        wr_m;
  logic [1:0]  mask_m;
  logic [2:0]  ltype_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;

  logic [0:0]  state_q;
  logic [0:0]  state_d;

  logic        st_op;
  logic        ld_op;
  logic        misalign;
  logic        access;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Store wins when both read and write are set; a store with no size is
  // treated as a non-memory op so it never raises a request.
  assign st_op = valid_m && wr_m && (mask_m != 2'b00);
  assign ld_op = valid_m && !wr_m && rd_m &&
                 (ltype_m >= LT_LB) && (ltype_m <= LT_LHU);

  always_comb begin
    misalign = 1'b0;
    if (st_op) begin
      if (mask_m == MK_SH)      misalign = addr_m[0];
      else if (mask_m == MK_SW) misalign = (addr_m[1:0] != 2'b00);
    end else if (ld_op) begin
      if (ltype_m == LT_LH || ltype_m == LT_LHU) misalign = addr_m[0];
      else if (ltype_m == LT_LW)                 misalign = (addr_m[1:0] != 2'b00);
    end
  end

  assign access    = (st_op || ld_op) && !misalign;
  assign MisalignM = misalign;
  assign StallM    = access && !dmem.DMemReady;

  // Memory-side outputs depend only on M state and DMemReady; the M register
  // holds during a stall, so address, data and enables stay stable in WAIT.
  assign dmem.DMemReq  = access;
  assign dmem.DMemAddr = {addr_m[31:2], 2'b00};

  always_comb begin
    dmem.DMemWE    = 4'b0000;
    dmem.DMemWData = 32'h0;
    if (access && st_op) begin
      case (mask_m)
        MK_SB: begin
          dmem.DMemWE    = 4'b1000 >> addr_m[1:0];
          dmem.DMemWData = {4{wdata_m[7:0]}};
        end
        MK_SH: begin
          dmem.DMemWE    = addr_m[1] ? 4'b0011 : 4'b1100;
          dmem.DMemWData = {2{wdata_m[15:0]}};
        end
        default: begin
          dmem.DMemWE    = 4'b1111;
          dmem.DMemWData = wdata_m;
        end
      endcase
    end
  end

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    case (addr_m[1:0])
      2'd0:    ld_byte = dmem.DMemRData[31:24];
      2'd1:    ld_byte = dmem.DMemRData[23:16];
      2'd2:    ld_byte = dmem.DMemRData[15:8];
      default: ld_byte = dmem.DMemRData[7:0];
    endcase
    ld_half = addr_m[1] ? dmem.DMemRData[15:0] : dmem.DMemRData[31:16];
    case (ltype_m)
      LT_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU:  ld_ext = {24'h0, ld_byte};
      LT_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      LT_LHU:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem.DMemRData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (access && !dmem.DMemReady) state_d = ST_WAIT;
      default: if (dmem.DMemReady)            state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      valid_m <= 1'b0;
      rd_m    <= 1'b0;
      wr_m    <= 1'b0;
      mask_m  <= 2'b00;
      ltype_m <= 3'd0;
      addr_m  <= 32'h0;
      wdata_m <= 32'h0;
    end else begin
      state_q <= state_d;
      if (!StallM) begin
        valid_m <= ValidE;
        rd_m    <= MemReadE;
        wr_m    <= MemWriteE;
        mask_m  <= MaskControlE;
        ltype_m <= LoadTypeE;
        addr_m  <= ALUOutE;
        wdata_m <= WriteDataE;
      end
    end
  end

  // Completion happens on the edge where the op is in M and not stalled;
  // misaligned ops retire silently with no writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ValidW    <= 1'b0;
      ReadDataW <= 32'h0;
    end else begin
      ValidW <= valid_m && !misalign && !StallM;
      if (ld_op && !misalign && !StallM) ReadDataW <= ld_ext;
    end
  end

endmodule

// File: doc/mem_align_stage.md
# mem_align_stage

Memory-stage load/store alignment and data-memory handshake unit for the 5-stage MIPS pipeline. It registers the execute-stage memory operation, including the byte-mask control produced by the mask decoder. It then drives byte-lane write enables and lane-replicated store data to data memory, and stalls the pipeline while memory is not ready. Load results are extracted, sign- or zero-extended, and registered into the writeback stage.

## Interface
Parameters:
- None.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ValidE` in 1: execute-stage instruction is valid.
- `MemReadE` in 1: instruction is a load.
- `MemWriteE` in 1: instruction is a store.
- `MaskControlE` in 2: store size. 00 none, 01 SB, 10 SH, 11 SW.
- `LoadTypeE` in 3: load type. 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- `ALUOutE` in 32: effective byte address.
- `WriteDataE` in 32: store data, right-justified.
- `DMemReq` out 1: memory request valid.
- `DMemAddr` out 32: word address, {addr[31:2], 2'b00}.
- `DMemWE` out 4: byte write enables. Bit 3 is byte lane 31:24.
- `DMemWData` out 32: lane-replicated store data.
- `DMemReady` in 1: memory accepts (write) or returns data (read) this cycle.
- `DMemRData` in 32: read data, valid when `DMemReady` is high on a read.
- `StallM` out 1: freeze IF/ID/E and hold E outputs.
- `MisalignM` out 1: one-cycle misaligned-access exception pulse.
- `ValidW` out 1: writeback-stage result valid.
- `ReadDataW` out 32: extended load data.

## Operation
- Byte order is big-endian: addr[1:0]=00 selects bits 31:24.
- E→M register captures all E inputs on a rising edge when `StallM`=0. While `StallM`=1, the register holds.
- Misalignment:
  - SH/LH/LHU with addr[0]=1 is misaligned.
  - SW/LW with addr[1:0]≠00 is misaligned.
  - A misaligned op raises `MisalignM` for its single M cycle, issues no request, does not stall, and yields `ValidW`=0.
- Store lanes:
  - SB: `DMemWData`={4{b}}, `DMemWE`=4'b1000>>addr[1:0].
  - SH: `DMemWData`={2{h}}, `DMemWE`=addr[1]?0011:1100.
  - SW: `DMemWData`=data, `DMemWE`=1111.
  - `DMemWE`=0000 whenever `DMemReq`=0.
- Load extraction uses the M-registered addr[1:0].
  - LB/LBU: select the byte, then sign- or zero-extend to 32 bits.
  - LH/LHU: select the halfword, then sign- or zero-extend to 32 bits.
  - LW: pass through unchanged.
- FSM states:
  - RUN: if M holds a valid aligned access, `DMemReq`=1. If `DMemReady`=1, the access completes and the state stays RUN. Otherwise `StallM`=1 and the next state is WAIT.
  - WAIT: `DMemReq`=1 with address, data and enables held stable; `StallM`=1. When `DMemReady`=1, the access completes, `StallM`=0 in that same cycle, and the next state is RUN.
- Completion:
  - A load writes `ReadDataW` and sets `ValidW`=1 at the next edge.
  - A store or a non-memory valid op sets `ValidW`=1 with `ReadDataW` unchanged.
  - An invalid op sets `ValidW`=0.
- `MemReadE` and `MemWriteE` both high is illegal. Store takes priority, and no read data is captured.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State becomes RUN and the M register is cleared (valid=0).
  - All outputs are 0: `DMemReq`, `DMemWE`, `DMemWData`, `DMemAddr`, `StallM`, `MisalignM`, `ValidW`, `ReadDataW`.
- Reset during WAIT abandons the request. `DMemReq`=0 from the cycle after the reset edge, and no `ValidW` is produced.
- `DMemReq`, `DMemWE`, `DMemWData`, `DMemAddr`, `StallM` and `MisalignM` are combinational from M state and `DMemReady`. There is no path from E inputs to these outputs.
- Latency: when memory is ready immediately, `ReadDataW` is valid 1 cycle after the op enters M. Each cycle with `DMemReady`=0 adds 1 cycle.
- Back-to-back accesses with `DMemReady` held at 1 sustain one access per cycle with zero stall.
- `DMemReady` while `DMemReq`=0 is ignored.

## Test plan
- Reset with `rst_n`=0 for 2 cycles, then release -> all outputs 0, FSM in RUN, and first op accepted on the next edge.
- SB, addr 0x1002, data 0x000000AB, ready=1 -> `DMemWE`=0010, `DMemWData`=0xABABABAB, `DMemAddr`=0x1000, `StallM`=0.
- LB, addr 0x2003, `DMemRData`=0x1234_56F0 -> `ReadDataW`=0xFFFFFFF0. Same access as LBU -> `ReadDataW`=0x000000F0. LH, addr 0x2002 -> `ReadDataW`=0x000056F0.
- LW, addr 0x3000, ready low for 3 cycles -> `StallM`=1 for exactly 3 cycles with request held stable, then `ReadDataW`=`DMemRData` and `ValidW`=1 on the following edge.
- SW, addr 0x4002 -> `MisalignM`=1 for 1 cycle, `DMemReq`=0, `ValidW`=0 next, no stall.
- Assert reset during WAIT, then hold `DMemReady`=1 -> no `ValidW`, `DMemReq`=0 after the reset edge, and subsequent SH at 0x10 gives `DMemWE`=1100.
